gen_pares_izq_der: RTL and testbench
====================================

# gen_pares_izq_der

Sequential word-pair generator that drives the comparator path from the other end. On request it scans every (palabraA, palabraB) pair of N-bit words in left-to-right order, A outer and B inner, and emits only the pairs that satisfy a selected relation (A<B, A==B, A>B, or all). Pairs leave through a valid/ready handshake. The block sources stimulus and reference data for the magnitude comparators of the izq-der network.

## Interface
- N, default 3, word width in bits; legal range 1..8.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a scan; sampled only in IDLE.
- rel  in  2  relation select, latched at start:
  - 00: A<B
  - 01: A==B
  - 10: A>B
  - 11: all pairs
- ready  in  1  downstream accepts the current pair.
- palabraA  out  N  current A word (registered counter).
- palabraB  out  N  current B word (registered counter).
- valid  out  1  current pair matches the latched relation; defined as state==RUN and match(palabraA, palabraB).
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse when a scan completes.
- count  out  2N+1  number of handshakes in the current or most recent scan.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1: latch rel, set palabraA=0, palabraB=0, count=0, go to RUN.
  - Otherwise hold all registers.
- RUN, once per cycle:
  - Compute match from the latched relation, unsigned compare, strict: exactly one of <, ==, > is true; rel=11 is always true.
  - Advance condition: !match, or (valid & ready).
  - If advance is false (match=1, ready=0), hold palabraA/B stable; valid stays high.
  - If advance is true: increment palabraB. When palabraB wraps from 2^N−1 to 0, also increment palabraA.
  - If valid & ready, count += 1 in the same cycle as the advance.
  - If the pair being advanced past is (2^N−1, 2^N−1), do not wrap: go to DONE with palabraA/B held at 2^N−1.
- DONE: done=1 for exactly one cycle, then go to IDLE. count holds its value until the next start.
- start while busy is ignored. A change on rel while busy has no effect.
- Expected totals per scan are 2^N·(2^N−1)/2 for < and for >, 2^N for ==, and 2^(2N) for all. For N=3 these are 28, 8, 28 and 64.

## Timing
- Reset values: state=IDLE, palabraA=0, palabraB=0, valid=0, busy=0, done=0, count=0, latched rel=00.
- Reset asserted mid-scan: on the next edge all registers take their reset values and no done pulse is produced.
- Start accepted at edge k:
  - First pair is visible after edge k, in cycle k+1.
  - busy rises in the same cycle.
- Throughput: one pair per cycle, whether skipped or accepted when ready=1. With ready held at 1, a full scan spends 2^(2N) cycles in RUN for any rel.
- done is high in cycle k+2^(2N)+1. busy falls one cycle later, together with the return to IDLE.
- Backpressure: every cycle with valid=1 and ready=0 adds one cycle to the scan.
- Handshake rule: while valid=1 and ready=0, palabraA and palabraB must not change. valid may drop only after a handshake, never spontaneously.
- Final pair:
  - With rel=01 or 11, (7,7) is a matching final pair for N=3. It requires a handshake before DONE is entered.
  - With rel=00 or 10, the final pair does not match, so it is skipped without a handshake.
- count saturation is impossible, because 2N+1 bits hold 2^(2N).

## Test plan
- Reset: assert rst with start=1 for 2 cycles → all outputs at reset values and state stays IDLE.
- rel=00, ready=1, N=3 → 28 handshakes in the order (0,1),(0,2)…(6,7); done asserted 65 cycles after the start edge; count=28.
- rel=01 with ready toggling 1,0,1,0 → pairs (0,0)…(7,7) in order, each held stable while ready=0; count=8; scan length 64 plus the number of stall cycles.
- rel=11, ready=1 → 64 consecutive handshakes, valid continuously high; count=64; done a single one-cycle pulse.
- start pulsed while busy, and rel changed mid-scan during a rel=10 scan → ignored; 28 pairs with A>B, the first being (1,0) and the last (7,6); count=28.
- rst asserted in the middle of a rel=00 scan, then start with rel=10 → no done pulse from the aborted scan; the new scan begins at (0,0) with count=0, and its first valid pair is (1,0).

Source files
------------

// File: rtl/gen_pares_izq_der_if.sv
`default_nettype none
// ============================================================================
//  Module  : gen_pares_izq_der_if
//  Brief   : Control and valid/ready pair bus of the word-pair generator.
//            master = generator side, slave = consumer / controller side.
//  Rev     : 1.0  initial release
// ============================================================================
interface gen_pares_izq_der_if #(
  parameter int N = 3
);
  logic             start;
  logic [1:0]       rel;
  logic             ready;
  logic [N-1:0]     palabraA;
  logic [N-1:0]     palabraB;
  logic             valid;
  logic             busy;
  logic             done;
  logic [2*N:0]     count;

  modport master (
    input  start, rel, ready,
    output palabraA, palabraB, valid, busy, done, count
  );

  modport slave (
    output start, rel, ready,
    input  palabraA, palabraB, valid, busy, done, count
  );
endinterface
`default_nettype wire

// File: rtl/gen_pares_izq_der.sv
`default_nettype none
// ============================================================================
//  Module  : gen_pares_izq_der
//  Brief   : Scans every (A,B) pair of N-bit words, A outer / B inner, and
//            presents the pairs matching the latched relation on a
//            valid/ready handshake. Non-matching pairs cost one cycle each.
//  Rev     : 1.0  initial release
// ============================================================================
module gen_pares_izq_der #(
  parameter int N = 3
) (
  input  wire                  clk,
  input  wire                  rst,
  gen_pares_izq_der_if.master  bus_io
);

  localparam logic [N-1:0] c_max_word = {N{1'b1}};
  localparam logic [N-1:0] c_word_one = {{(N-1){1'b0}}, 1'b1};
  localparam logic [2*N:0] c_cnt_one  = {{(2*N){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [1:0]     rel_q, rel_d;
  logic [2*N:0]   count_q, count_d;

  logic           w_match;
  logic           w_valid;
  logic           w_fire;
  logic           w_advance;
  logic           w_last;

  // Relation test on the current pair, unsigned compare.
  always_comb begin
    w_match = 1'b0;
    unique case (rel_q)
      2'b00:   w_match = (a_q <  b_q);
      2'b01:   w_match = (a_q == b_q);
      2'b10:   w_match = (a_q >  b_q);
      default: w_match = 1'b1;
    endcase
  end

  assign w_valid   = (state_q == ST_RUN) && w_match;
  assign w_fire    = w_valid && bus_io.ready;
  // A matching pair is only left behind once it has been handed over.
  assign w_advance = !w_match || w_fire;
  assign w_last    = (a_q == c_max_word) && (b_q == c_max_word);

  // Next-state logic: scan counters, relation latch, handshake counter.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rel_d   = rel_q;
    count_d = count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus_io.start) begin
          rel_d   = bus_io.rel;
          a_d     = '0;
          b_d     = '0;
          count_d = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_fire) begin
          count_d = count_q + c_cnt_one;
        end
        if (w_advance) begin
          if (w_last) begin
            // Final pair: park on (max,max) rather than wrapping.
            state_d = ST_DONE;
          end else begin
            b_d = b_q + c_word_one;
            if (b_q == c_max_word) begin
              a_d = a_q + c_word_one;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rel_q   <= 2'b00;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rel_q   <= rel_d;
      count_q <= count_d;
    end
  end

  assign bus_io.palabraA = a_q;
  assign bus_io.palabraB = b_q;
  assign bus_io.valid    = w_valid;
  assign bus_io.busy     = (state_q != ST_IDLE);
  assign bus_io.done     = (state_q == ST_DONE);
  assign bus_io.count    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_gen_pares_izq_der.sv
`default_nettype none
// ============================================================================
//  Module  : tb_gen_pares_izq_der
//  Brief   : Self-checking bench for gen_pares_izq_der (N=3).
//  Rev     : 1.0  initial release
// ============================================================================
module tb_gen_pares_izq_der;

  localparam int N = 3;
  localparam int NPAIRS = 1 << (2 * N);

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
  } pair_t;

  typedef struct {
    logic [1:0] rel;
    int         ready_mode;   // 0: ready held 1, 1: ready toggles 1,0,1,0
    bit         disturb;      // pulse start and change rel mid-scan
    int         exp_count;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_errors = 0;

  pair_t sb[$];
  vec_t  vecs[5];

  gen_pares_izq_der_if #(.N(N)) bus ();

  gen_pares_izq_der #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic bit ref_match(input logic [1:0] r, input int a, input int b);
    case (r)
      2'b00:   return a < b;
      2'b01:   return a == b;
      2'b10:   return a > b;
      default: return 1'b1;
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_A"},     32'(bus.palabraA), 0);
    check({tag, "_B"},     32'(bus.palabraB), 0);
    check({tag, "_valid"}, 32'(bus.valid), 0);
    check({tag, "_busy"},  32'(bus.busy), 0);
    check({tag, "_done"},  32'(bus.done), 0);
    check({tag, "_count"}, 32'(bus.count), 0);
  endtask

  // One complete scan, scoreboarded pair by pair.
  task automatic run_scan(input logic [1:0] r, input int ready_mode,
                          input bit disturb, input int exp_count);
    int           cyc;
    int           stalls;
    bit           held;
    bit           seen_done;
    logic [N-1:0] ha, hb;
    pair_t        p;
    sb.delete();
    for (int a = 0; a < (1 << N); a++)
      for (int b = 0; b < (1 << N); b++)
        if (ref_match(r, a, b)) begin
          p.a = a[N-1:0];
          p.b = b[N-1:0];
          sb.push_back(p);
        end
    check("sb_size", 32'(sb.size()), 32'(exp_count));

    @(negedge clk);
    bus.rel   = r;
    bus.start = 1'b1;
    bus.ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    check("first_A",     32'(bus.palabraA), 0);
    check("first_B",     32'(bus.palabraB), 0);
    check("first_count", 32'(bus.count), 0);
    check("first_busy",  32'(bus.busy), 1);

    cyc = 1; stalls = 0; held = 0; seen_done = 0; ha = '0; hb = '0;
    while (!seen_done && cyc < 400) begin
      bus.ready = (ready_mode == 0) ? 1'b1 : ((cyc % 2) == 1);
      if (disturb && cyc >= 10) begin
        bus.rel   = ~r;
        bus.start = (cyc == 10) || (cyc == 30);
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        seen_done = 1;
        check("done_cycle", 32'(cyc), 32'(NPAIRS + 1 + stalls));
        check("done_count", 32'(bus.count), 32'(exp_count));
        check("done_busy",  32'(bus.busy), 1);
        check("sb_left",    32'(sb.size()), 0);
      end else begin
        if (held) begin
          check("stall_A", 32'(bus.palabraA), 32'(ha));
          check("stall_B", 32'(bus.palabraB), 32'(hb));
          check("stall_valid", 32'(bus.valid), 1);
        end
        held = 0;
        if (r == 2'b11) check("valid_all", 32'(bus.valid), 1);
        if (bus.valid) begin
          check("sb_nonempty", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            check("pair_A", 32'(bus.palabraA), 32'(sb[0].a));
            check("pair_B", 32'(bus.palabraB), 32'(sb[0].b));
            if (bus.ready) begin
              void'(sb.pop_front());
            end else begin
              stalls++;
              held = 1;
              ha = bus.palabraA;
              hb = bus.palabraB;
            end
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    bus.ready = 1'b0;
    check("scan_timeout", 32'(seen_done), 1);
    check("post_done",  32'(bus.done), 0);
    check("post_busy",  32'(bus.busy), 0);
    check("post_count", 32'(bus.count), 32'(exp_count));
  endtask

  initial begin
    vecs[0] = '{rel: 2'b00, ready_mode: 0, disturb: 1'b0, exp_count: 28};
    vecs[1] = '{rel: 2'b01, ready_mode: 1, disturb: 1'b0, exp_count: 8};
    vecs[2] = '{rel: 2'b11, ready_mode: 0, disturb: 1'b0, exp_count: 64};
    vecs[3] = '{rel: 2'b10, ready_mode: 0, disturb: 1'b1, exp_count: 28};
    vecs[4] = '{rel: 2'b11, ready_mode: 1, disturb: 1'b0, exp_count: 64};

    // Reset with start held high: nothing may leave IDLE.
    rst = 1'b1; bus.start = 1'b1; bus.rel = 2'b11; bus.ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0; bus.start = 1'b0; bus.ready = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(bus.busy), 0);

    for (int i = 0; i < 5; i++)
      run_scan(vecs[i].rel, vecs[i].ready_mode, vecs[i].disturb, vecs[i].exp_count);

    // Abort a rel=00 scan with reset; no done may follow.
    @(negedge clk);
    bus.rel = 2'b00; bus.start = 1'b1; bus.ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_busy_before", 32'(bus.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(bus.done), 0);
    end
    run_scan(2'b10, 0, 1'b0, 28);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
